// File: rtl/openmips_pkg.sv
// Shared constants and types for the openMIPS pipeline control logic.
package openmips_pkg;

  // Stage indices within the stall vector.
  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  // A stalling stage freezes itself and every stage upstream of it.
  localparam logic [5:0] STALL_ID  = 6'b000111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_MEM = 6'b011111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MULTI = 2'd1,
    S_FLUSH = 2'd2
  } pipe_ctrl_state_t;

endpackage

// File: rtl/dr_reg.sv
// Plain D flop bank with synchronous active-high reset to zero and enable.
module dr_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Capture d when enabled; reset clears to zero.
  always_ff @(posedge clk) begin
    if (rst)     r_q <= '0;
    else if (en) r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_ctrl_mc_counter.sv
// Loadable down-counter; is_one flags the final cycle of a count.
module mc_counter #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_one
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst)                      r_cnt <= '0;
    else if (load)                r_cnt <= load_val;
    else if (dec && r_cnt != '0)  r_cnt <= r_cnt - W'(1);
  end

  assign is_one = (r_cnt == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests, sequences
// multi-cycle EX operations and turns exceptions into a flush with redirect PC.
module pipe_ctrl
  import openmips_pkg::*;
#(
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              id_stallreq,
  input  logic              mem_stallreq,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_cycles,
  input  logic              excp_valid,
  input  logic [ADDR_W-1:0] excp_pc,
  output logic [5:0]        stall,
  output logic              ex_mc_busy,
  output logic              ex_mc_abort,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

  pipe_ctrl_state_t r_state;
  pipe_ctrl_state_t w_state_nxt;

  logic             w_excp;
  logic             w_ex_src;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_dec;
  logic             w_cnt_is_one;
  logic             w_fcnt_load;
  logic             w_fcnt_dec;
  logic             w_fcnt_is_one;
  logic             w_pc_cap;
  logic             w_abort_nxt;
  logic             w_flush_nxt;
  logic [5:0]       w_stall;

  mc_counter #(.W(CNT_W)) u_mc_cnt (
    .clk      (clk),
    .rst      (rst_),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .dec      (w_cnt_dec),
    .is_one   (w_cnt_is_one)
  );

  mc_counter #(.W(FW)) u_flush_cnt (
    .clk      (clk),
    .rst      (rst_),
    .load     (w_fcnt_load),
    .load_val (FW'(FLUSH_CYCLES)),
    .dec      (w_fcnt_dec),
    .is_one   (w_fcnt_is_one)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst_) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and counter control; an exception preempts any EX start.
  always_comb begin
    w_state_nxt = r_state;
    w_excp      = 1'b0;
    w_ex_src    = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    w_cnt_dec   = 1'b0;
    w_fcnt_load = 1'b0;
    w_fcnt_dec  = 1'b0;
    w_pc_cap    = 1'b0;
    w_abort_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (excp_valid) begin
          w_excp      = 1'b1;
          w_pc_cap    = 1'b1;
          w_fcnt_load = 1'b1;
          w_state_nxt = S_FLUSH;
        end else if (ex_mc_start && ex_mc_cycles != '0) begin
          w_ex_src = 1'b1;
          // The start cycle itself is the first stall cycle, so MULTI covers S-1 more.
          if (ex_mc_cycles > CNT_W'(1)) begin
            w_cnt_load  = 1'b1;
            w_cnt_val   = ex_mc_cycles - CNT_W'(1);
            w_state_nxt = S_MULTI;
          end
        end
      end
      S_MULTI: begin
        if (excp_valid) begin
          w_excp      = 1'b1;
          w_pc_cap    = 1'b1;
          w_fcnt_load = 1'b1;
          w_abort_nxt = 1'b1;
          w_cnt_load  = 1'b1;
          w_state_nxt = S_FLUSH;
        end else begin
          w_ex_src  = 1'b1;
          w_cnt_dec = 1'b1;
          if (w_cnt_is_one) w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH: begin
        w_fcnt_dec = 1'b1;
        if (w_fcnt_is_one) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Zero-latency stall merge; reset, exceptions and flushing force it clear.
  always_comb begin
    w_stall = '0;
    if (!rst_ && !w_excp && r_state != S_FLUSH) begin
      if (id_stallreq)  w_stall = w_stall | STALL_ID;
      if (w_ex_src)     w_stall = w_stall | STALL_EX;
      if (mem_stallreq) w_stall = w_stall | STALL_MEM;
    end
  end

  assign w_flush_nxt = (w_state_nxt == S_FLUSH);

  dr_reg #(.W(1)) u_flush_q (
    .clk (clk),
    .rst (rst_),
    .en  (1'b1),
    .d   (w_flush_nxt),
    .q   (flush)
  );

  dr_reg #(.W(1)) u_abort_q (
    .clk (clk),
    .rst (rst_),
    .en  (1'b1),
    .d   (w_abort_nxt),
    .q   (ex_mc_abort)
  );

  dr_reg #(.W(ADDR_W)) u_pc_q (
    .clk (clk),
    .rst (rst_),
    .en  (w_pc_cap),
    .d   (excp_pc),
    .q   (new_pc)
  );

  assign stall      = w_stall;
  assign ex_mc_busy = w_ex_src && !rst_;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle expectations go into a
// scoreboard queue when the stimulus is driven and are popped on sampling.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic        id_stallreq;
  logic        mem_stallreq;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        excp_valid;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        ex_mc_busy;
  logic        ex_mc_abort;
  logic        flush;
  logic [31:0] new_pc;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        busy;
    logic        abort;
    logic        flush;
    bit          chk_pc;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl #(.CNT_W(6), .FLUSH_CYCLES(1), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_         (rst_),
    .id_stallreq  (id_stallreq),
    .mem_stallreq (mem_stallreq),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .excp_valid   (excp_valid),
    .excp_pc      (excp_pc),
    .stall        (stall),
    .ex_mc_busy   (ex_mc_busy),
    .ex_mc_abort  (ex_mc_abort),
    .flush        (flush),
    .new_pc       (new_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, queue its expectation,
  // then sample the outputs shortly afterwards and score them.
  task automatic step(input string tag, input bit r, input bit id, input bit mem,
                      input bit st, input logic [5:0] cyc, input bit ev,
                      input logic [31:0] epc, input logic [5:0] e_stall,
                      input bit e_busy, input bit e_abort, input bit e_flush,
                      input bit e_chk_pc, input logic [31:0] e_pc);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_         = r;
    id_stallreq  = id;
    mem_stallreq = mem;
    ex_mc_start  = st;
    ex_mc_cycles = cyc;
    excp_valid   = ev;
    excp_pc      = epc;
    e.tag = tag; e.stall = e_stall; e.busy = e_busy; e.abort = e_abort;
    e.flush = e_flush; e.chk_pc = e_chk_pc; e.pc = e_pc;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    check_eq({got.tag, ".stall"}, {26'd0, stall}, {26'd0, got.stall});
    check_eq({got.tag, ".busy"},  {31'd0, ex_mc_busy}, {31'd0, got.busy});
    check_eq({got.tag, ".abort"}, {31'd0, ex_mc_abort}, {31'd0, got.abort});
    check_eq({got.tag, ".flush"}, {31'd0, flush}, {31'd0, got.flush});
    if (got.chk_pc) check_eq({got.tag, ".new_pc"}, new_pc, got.pc);
  endtask

  // Quiet cycle: no requests, only the expected outputs vary.
  task automatic idle(input string tag, input logic [5:0] e_stall, input bit e_busy,
                      input bit e_abort, input bit e_flush, input bit e_chk_pc,
                      input logic [31:0] e_pc);
    step(tag, 0, 0, 0, 0, 6'd0, 0, 32'h0, e_stall, e_busy, e_abort, e_flush, e_chk_pc, e_pc);
  endtask

  initial begin
    rst_ = 1'b1; id_stallreq = 1'b1; mem_stallreq = 1'b1; ex_mc_start = 1'b1;
    ex_mc_cycles = 6'd3; excp_valid = 1'b1; excp_pc = 32'hFFFF_FFFF;

    // Reset with every request high.
    step("rst0", 1, 1, 1, 1, 6'd3, 1, 32'hFFFF_FFFF, 6'b000000, 0, 0, 0, 1, 32'h0);
    step("rst1", 1, 1, 1, 1, 6'd3, 1, 32'hFFFF_FFFF, 6'b000000, 0, 0, 0, 1, 32'h0);
    idle("post_rst", 6'b000000, 0, 0, 0, 1, 32'h0);

    // ID request alone.
    step("id", 0, 1, 0, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 0, 0, 0, 32'h0);
    idle("id_done", 6'b000000, 0, 0, 0, 0, 32'h0);

    // Multi-cycle op, S = 3.
    step("mc3_t0", 0, 0, 0, 1, 6'd3, 0, 32'h0, 6'b001111, 1, 0, 0, 0, 32'h0);
    idle("mc3_t1", 6'b001111, 1, 0, 0, 0, 32'h0);
    idle("mc3_t2", 6'b001111, 1, 0, 0, 0, 32'h0);
    idle("mc3_t3", 6'b000000, 0, 0, 0, 0, 32'h0);

    // Same op with MEM stalling t+1..t+5; the EX count keeps running.
    step("mcm_t0", 0, 0, 0, 1, 6'd3, 0, 32'h0, 6'b001111, 1, 0, 0, 0, 32'h0);
    step("mcm_t1", 0, 0, 1, 0, 6'd0, 0, 32'h0, 6'b011111, 1, 0, 0, 0, 32'h0);
    step("mcm_t2", 0, 0, 1, 0, 6'd0, 0, 32'h0, 6'b011111, 1, 0, 0, 0, 32'h0);
    step("mcm_t3", 0, 0, 1, 0, 6'd0, 0, 32'h0, 6'b011111, 0, 0, 0, 0, 32'h0);
    step("mcm_t4", 0, 0, 1, 0, 6'd0, 0, 32'h0, 6'b011111, 0, 0, 0, 0, 32'h0);
    step("mcm_t5", 0, 0, 1, 0, 6'd0, 0, 32'h0, 6'b011111, 0, 0, 0, 0, 32'h0);
    idle("mcm_t6", 6'b000000, 0, 0, 0, 0, 32'h0);

    // S = 1 stalls one cycle only; S = 0 is ignored.
    step("mc1_t0", 0, 0, 0, 1, 6'd1, 0, 32'h0, 6'b001111, 1, 0, 0, 0, 32'h0);
    idle("mc1_t1", 6'b000000, 0, 0, 0, 0, 32'h0);
    step("mc0", 0, 0, 0, 1, 6'd0, 0, 32'h0, 6'b000000, 0, 0, 0, 0, 32'h0);

    // Exception kills an 8-cycle op at t+2.
    step("ab_t0", 0, 0, 0, 1, 6'd8, 0, 32'h0, 6'b001111, 1, 0, 0, 0, 32'h0);
    idle("ab_t1", 6'b001111, 1, 0, 0, 0, 32'h0);
    step("ab_t2", 0, 0, 0, 0, 6'd0, 1, 32'h0000_0100, 6'b000000, 0, 0, 0, 0, 32'h0);
    idle("ab_t3", 6'b000000, 0, 1, 1, 1, 32'h0000_0100);
    step("ab_t4", 0, 1, 0, 0, 6'd0, 0, 32'h0, 6'b000111, 0, 0, 0, 0, 32'h0);
    idle("ab_t5", 6'b000000, 0, 0, 0, 0, 32'h0);

    // Exception together with a start: no stall, no busy; FLUSH ignores requests.
    step("xs_t0", 0, 0, 0, 1, 6'd4, 1, 32'h0000_0200, 6'b000000, 0, 0, 0, 0, 32'h0);
    step("xs_t1", 0, 1, 1, 1, 6'd4, 1, 32'h0000_0999, 6'b000000, 0, 0, 1, 1, 32'h0000_0200);
    idle("xs_t2", 6'b000000, 0, 0, 0, 0, 32'h0);

    // Reset during FLUSH drops the pending flush.
    step("rf_t0", 0, 0, 0, 1, 6'd5, 1, 32'h0000_0300, 6'b000000, 0, 0, 0, 0, 32'h0);
    step("rf_t1", 1, 0, 0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0, 1, 1, 32'h0000_0300);
    idle("rf_t2", 6'b000000, 0, 0, 0, 1, 32'h0);

    // Reset during MULTI returns to IDLE.
    step("rm_t0", 0, 0, 0, 1, 6'd8, 0, 32'h0, 6'b001111, 1, 0, 0, 0, 32'h0);
    idle("rm_t1", 6'b001111, 1, 0, 0, 0, 32'h0);
    step("rm_t2", 1, 1, 1, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0, 0, 0, 32'h0);
    idle("rm_t3", 6'b000000, 0, 0, 0, 1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
